// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, arbiter states and requester count
package alu_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLL = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response handshake bundle between requesters and the ALU arbiter
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  import alu_pkg::*;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_op1;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_op2;
  logic [NUM_REQ-1:0][2:0]            req_ctrl;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_sum;
  logic                  rsp_eq;

  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_eq
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_eq
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, purely combinational
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    // On a tie the requester that did not win last time gets the slot
    if (req == 2'b11) begin
      gnt_idx = ~last;
      gnt     = last ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      gnt_idx = 1'b0;
      gnt     = 2'b01;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
      gnt     = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_arbiter_if.slave          bus,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [2:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_sum,
  input  logic                  alu_eq
);

  arb_state_t            state, state_nxt;
  logic                  last_gnt;
  logic [1:0]            gnt;
  logic                  gnt_idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, sum_q;
  logic [2:0]            ctrl_q;
  logic                  id_q, eq_q;

  rr_arbiter2 u_rr (
    .req     (bus.req_valid),
    .last    (last_gnt),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // req_ready is a function of req_valid and state only; rsp_ready never reaches it
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) bus.req_ready = gnt;
        accept = |gnt;
        if (accept) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q    <= '0;
      op2_q    <= '0;
      ctrl_q   <= 3'b000;
      id_q     <= 1'b0;
      last_gnt <= 1'b1;
      sum_q    <= '0;
      eq_q     <= 1'b0;
    end else begin
      if (accept) begin
        op1_q    <= bus.req_op1[gnt_idx];
        op2_q    <= bus.req_op2[gnt_idx];
        ctrl_q   <= bus.req_ctrl[gnt_idx];
        id_q     <= gnt_idx;
        last_gnt <= gnt_idx;
      end
      if (state == EXEC) begin
        sum_q <= alu_sum;
        eq_q  <= alu_eq;
      end
    end
  end

  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign alu_ctrl      = ctrl_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_eq    = eq_q;

endmodule
